// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit period, used by
// both the transmitter and the receiver.
package uart_pkg;

    // 50 MHz system clock at 115200 baud.
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: flags the last cycle of a bit and the cycle before it.
// Wraps to zero on its own at every bit boundary, or when clear is asserted.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign bit_end     = (cnt_q == CntW'(CLKS_PER_BIT - 1));
    assign bit_pre_end = (cnt_q == CntW'(CLKS_PER_BIT - 2));

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS payload LSB first, optional even
// parity (define UART_TX_PARITY_EN), one stop bit. All outputs registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned IdxW = $clog2(DATA_BITS);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 serial_q, serial_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cnt_clear;
    logic                 bit_end;
    logic                 bit_pre_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear       (cnt_clear),
        .bit_end     (bit_end),
        .bit_pre_end (bit_pre_end)
    );

    // The final stop-bit cycle is the tx_done/IDLE cycle, so STOP itself lasts
    // one cycle short; this lets a request in the done cycle start the next
    // frame with no idle gap.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        serial_d  = serial_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_clear = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_clear = 1'b1;
                serial_d  = 1'b1;
                busy_d    = 1'b0;
                if (tx_start) begin
                    state_d  = StStart;
                    shift_d  = tx_data;
                    idx_d    = '0;
                    serial_d = 1'b0;
                    busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d  = StData;
                    serial_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == IdxW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = StParity;
                        serial_d = parity_q;
`else
                        state_d  = StStop;
                        serial_d = 1'b1;
`endif
                    end else begin
                        idx_d    = idx_q + IdxW'(1);
                        serial_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d  = StStop;
                    serial_d = 1'b1;
                end
            end
`endif
            StStop: begin
                serial_d = 1'b1;
                if (bit_pre_end) begin
                    state_d   = StIdle;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    cnt_clear = 1'b1;
                end
            end
            default: begin
                state_d  = StIdle;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            idx_q    <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_serial = serial_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, DATA_BITS=8; expected line
// waveform is rebuilt per cycle from the payload byte.
module tb_uart_tx;

    localparam int unsigned CLKS  = 4;
    localparam int unsigned DBITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = (DBITS + 3) * CLKS;
`else
    localparam int FRAME = (DBITS + 2) * CLKS;
`endif

    localparam int ModeNorm     = 0;
    localparam int ModeHold     = 1;
    localparam int ModeScramble = 2;
    localparam int ModeBusyReq  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx #(
        .CLKS_PER_BIT (CLKS),
        .DATA_BITS    (DBITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line level in cycle k (k=1 is the cycle right after the accepting edge).
    function automatic logic exp_serial(input logic [7:0] d, input int k);
        int b;
        b = (k - 1) / CLKS;
        if (b == 0) return 1'b0;
        if (b <= DBITS) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == DBITS + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called at a negedge; the next posedge accepts the frame.
    task automatic run_frame(input string tag, input logic [7:0] data, input int mode);
        tx_data  = data;
        tx_start = 1'b1;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            check_eq($sformatf("%s serial c%0d", tag, k), tx_serial, exp_serial(data, k));
            check_eq($sformatf("%s busy c%0d", tag, k), tx_busy, (k < FRAME));
            check_eq($sformatf("%s done c%0d", tag, k), tx_done, (k == FRAME));
            if (mode != ModeHold) tx_start = 1'b0;
            if (mode == ModeScramble) tx_data = data ^ 8'(k * 37 + 1);
            if (mode == ModeBusyReq && k == 10) begin
                tx_start = 1'b1;
                tx_data  = 8'h3C;
            end
        end
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq($sformatf("%s idle c%0d", tag, i), {tx_serial, tx_busy, tx_done}, 3'b100);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst serial", tx_serial, 1'b1);
        check_eq("rst busy", tx_busy, 1'b0);
        check_eq("rst done", tx_done, 1'b0);
        rst = 1'b0;
        check_idle("post_rst", 3);

        // Single frame
        run_frame("a5", 8'hA5, ModeNorm);
        check_idle("a5", 5);

        // Back-to-back with tx_start held high
        run_frame("b2b0", 8'h00, ModeHold);
        run_frame("b2b1", 8'hFF, ModeNorm);
        check_idle("b2b", 5);

        // Request while busy is dropped
        run_frame("busy55", 8'h55, ModeBusyReq);
        check_idle("busy55", FRAME + 5);

        // Reset during data bit 3
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (17) @(negedge clk);
        check_eq("midrst pre serial", tx_serial, 1'b0);
        check_eq("midrst pre busy", tx_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst serial", tx_serial, 1'b1);
        check_eq("midrst busy", tx_busy, 1'b0);
        check_eq("midrst done", tx_done, 1'b0);
        rst = 1'b0;
        check_idle("midrst", FRAME + 5);
        run_frame("f12", 8'h12, ModeNorm);
        check_idle("f12", 3);

        // Reset wins over a simultaneous request
        rst      = 1'b1;
        tx_start = 1'b1;
        tx_data  = 8'h99;
        @(negedge clk);
        check_eq("rst_vs_start serial", tx_serial, 1'b1);
        check_eq("rst_vs_start busy", tx_busy, 1'b0);
        rst      = 1'b0;
        tx_start = 1'b0;
        check_idle("rst_vs_start", FRAME + 2);

        // Payload latched at acceptance
        run_frame("c3", 8'hC3, ModeScramble);
        check_idle("c3", 3);

        // Parity-sensitive payloads (odd and even popcount)
        run_frame("p07", 8'h07, ModeNorm);
        run_frame("p03", 8'h03, ModeNorm);
        check_idle("p03", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
